// File: rtl/lstm_cell_stream.sv
`default_nettype none
// ============================================================================
// Module   : lstm_cell_stream
// Function : LSTM pointwise cell (hard-sigmoid/hard-tanh, saturating fixed
//            point). It holds the cell state across timesteps and streams h
//            out serially, one lane per handshake.
// Revision : 1.0  initial release
// ============================================================================
module lstm_cell_stream #(
  parameter int ELEMENT_BITS = 8,
  parameter int FRAC_BITS    = 5,
  parameter int FEATURES     = 4,
  localparam int IDX_BITS    = (FEATURES > 1) ? $clog2(FEATURES) : 1
) (
  input  logic                             sys_clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             seq_start,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wi_xt,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wf_xt,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wg_xt,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wo_xt,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ELEMENT_BITS-1:0]          h_ser,
  output logic [IDX_BITS-1:0]              h_idx,
  output logic                             h_last,
  output logic [FEATURES*ELEMENT_BITS-1:0] cell_state
);

  localparam int EB = ELEMENT_BITS;
  localparam int VW = FEATURES * ELEMENT_BITS;

  localparam logic signed [EB:0]     c_ONE_E  = (EB+1)'(2**FRAC_BITS);
  localparam logic signed [EB:0]     c_NONE_E = (EB+1)'(-(2**FRAC_BITS));
  localparam logic signed [EB:0]     c_HALF_E = (EB+1)'(2**(FRAC_BITS-1));
  localparam logic signed [EB:0]     c_MAX_E  = (EB+1)'((2**(EB-1)) - 1);
  localparam logic signed [EB:0]     c_MIN_E  = (EB+1)'(-(2**(EB-1)));
  localparam logic signed [2*EB-1:0] c_MAX_P  = (2*EB)'((2**(EB-1)) - 1);
  localparam logic signed [2*EB-1:0] c_MIN_P  = (2*EB)'(-(2**(EB-1)));
  localparam logic [IDX_BITS-1:0]    c_LAST_IDX = IDX_BITS'(FEATURES - 1);

  function automatic logic signed [EB-1:0] f_hsig(input logic signed [EB-1:0] x);
    logic signed [EB:0] t;
    t = (EB+1)'(x) >>> 2;
    t = t + c_HALF_E;
    if (t[EB])            return '0;
    else if (t > c_ONE_E) return c_ONE_E[EB-1:0];
    else                  return t[EB-1:0];
  endfunction

  function automatic logic signed [EB-1:0] f_htanh(input logic signed [EB-1:0] x);
    logic signed [EB:0] t;
    t = (EB+1)'(x);
    if (t > c_ONE_E)       return c_ONE_E[EB-1:0];
    else if (t < c_NONE_E) return c_NONE_E[EB-1:0];
    else                   return t[EB-1:0];
  endfunction

  // Full-width product, arithmetic shift gives floor rounding before clamping.
  function automatic logic signed [EB-1:0] f_mul(input logic signed [EB-1:0] a,
                                                 input logic signed [EB-1:0] b);
    logic signed [2*EB-1:0] p;
    p = (2*EB)'(a) * (2*EB)'(b);
    p = p >>> FRAC_BITS;
    if (p > c_MAX_P)      return c_MAX_P[EB-1:0];
    else if (p < c_MIN_P) return c_MIN_P[EB-1:0];
    else                  return p[EB-1:0];
  endfunction

  function automatic logic signed [EB-1:0] f_add(input logic signed [EB-1:0] a,
                                                 input logic signed [EB-1:0] b);
    logic signed [EB:0] s;
    s = (EB+1)'(a) + (EB+1)'(b);
    if (s > c_MAX_E)      return c_MAX_E[EB-1:0];
    else if (s < c_MIN_E) return c_MIN_E[EB-1:0];
    else                  return s[EB-1:0];
  endfunction

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_2    = 3'd2,
    S_3    = 3'd3,
    S_SER  = 3'd4
  } state_t;

  state_t              r_state;
  logic [VW-1:0]       r_wi, r_wf, r_wg, r_wo;
  logic                r_seq_start;
  logic [VW-1:0]       r_i, r_c, r_h;
  logic [VW-1:0]       w_i_nxt, w_c_nxt, w_h_nxt;
  logic [EB-1:0]       w_h_lane [FEATURES];
  logic [IDX_BITS-1:0] w_idx_inc;

  assign w_idx_inc = h_idx + IDX_BITS'(1);

  for (genvar k = 0; k < FEATURES; k++) begin : g_lane
    logic [EB-1:0] w_c_prev;
    // A new sequence starts from a zero cell state regardless of cell_state.
    assign w_c_prev = r_seq_start ? '0 : cell_state[k*EB +: EB];
    assign w_i_nxt[k*EB +: EB] = f_mul(f_hsig(r_wi[k*EB +: EB]), f_htanh(r_wg[k*EB +: EB]));
    assign w_c_nxt[k*EB +: EB] = f_add(f_mul(f_hsig(r_wf[k*EB +: EB]), w_c_prev),
                                       r_i[k*EB +: EB]);
    assign w_h_nxt[k*EB +: EB] = f_mul(f_htanh(r_c[k*EB +: EB]), f_hsig(r_wo[k*EB +: EB]));
    assign w_h_lane[k] = r_h[k*EB +: EB];
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wi        <= '0;
      r_wf        <= '0;
      r_wg        <= '0;
      r_wo        <= '0;
      r_seq_start <= 1'b0;
      r_i         <= '0;
      r_c         <= '0;
      r_h         <= '0;
      cell_state  <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      h_ser       <= '0;
      h_idx       <= '0;
      h_last      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_wi        <= wi_xt;
            r_wf        <= wf_xt;
            r_wg        <= wg_xt;
            r_wo        <= wo_xt;
            r_seq_start <= seq_start;
            in_ready    <= 1'b0;
            r_state     <= S_1;
          end
        end
        S_1: begin
          r_i     <= w_i_nxt;
          r_state <= S_2;
        end
        S_2: begin
          r_c     <= w_c_nxt;
          r_state <= S_3;
        end
        S_3: begin
          r_h        <= w_h_nxt;
          cell_state <= r_c;
          r_state    <= S_SER;
        end
        S_SER: begin
          // First SER cycle only loads lane 0; afterwards advance per handshake.
          if (!out_valid) begin
            out_valid <= 1'b1;
            h_ser     <= w_h_lane[0];
            h_idx     <= '0;
            h_last    <= (c_LAST_IDX == '0);
          end else if (out_ready) begin
            if (h_last) begin
              out_valid <= 1'b0;
              h_last    <= 1'b0;
              h_idx     <= '0;
              in_ready  <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              h_ser  <= w_h_lane[w_idx_inc];
              h_idx  <= w_idx_inc;
              h_last <= (w_idx_inc == c_LAST_IDX);
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
